// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: IDLE/CLEAR FSM that sweeps one entry per cycle and
// reports busy for exactly DEPTH cycles after an accepted clear request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        // clr_req is deliberately ignored here: a sweep is never restarted.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign sweep_addr = idx_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, 2 registered read ports with write-first bypass, 1 write port,
// and a sequenced clear. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to 0.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_fire;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .busy       (busy),
    .sweep_addr (sweep_addr)
  );

  // While idle, busy=0 so any clr_req is the one being accepted this edge.
`ifdef REGFILE_ZERO_REG_EN
  assign wr_fire = wr_en && !busy && !clr_req && (wr_addr != '0);
`else
  assign wr_fire = wr_en && !busy && !clr_req;
`endif

  // NOTE: the array is flop-based and must reset asynchronously to zero,
  // so every entry is cleared in the reset branch (not a RAM macro).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (busy) begin
      mem_q[sweep_addr] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A dropped write must not bypass, so the bypass keys off wr_fire.
  always_comb begin
    rd_a_d = mem_q[rd_addr_a];
    rd_b_d = mem_q[rd_addr_b];
    if (wr_fire && (wr_addr == rd_addr_a)) rd_a_d = wr_data;
    if (wr_fire && (wr_addr == rd_addr_b)) rd_b_d = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: vector table for write/read/bypass plus
// hand sequences for clear sweep, clear/write collision and mid-sweep reset.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        clr_req = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [15:0] Z0 = 16'h0000;
  localparam logic [15:0] ZF = 16'h0000;
`else
  localparam logic [15:0] Z0 = 16'h5555;
  localparam logic [15:0] ZF = 16'hFFFF;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t vecs[9];

  regfile_2r1w dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; one rising edge later, sample again.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;

    vecs[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd0, 3'd1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, 16'h1234, 16'h1234};
    vecs[3] = '{1'b1, 3'd1, 16'h0A0A, 3'd3, 3'd5, 16'h1234, 16'hBEEF};
    vecs[4] = '{1'b1, 3'd7, 16'h7777, 3'd7, 3'd1, 16'h7777, 16'h0A0A};
    vecs[5] = '{1'b1, 3'd0, 16'h5555, 3'd0, 3'd2, Z0,       16'h0000};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, Z0,       16'h7777};
    vecs[7] = '{1'b1, 3'd5, 16'hCAFE, 3'd5, 3'd3, 16'hCAFE, 16'h1234};
    vecs[8] = '{1'b0, 3'd5, 16'hFFFF, 3'd5, 3'd5, 16'hCAFE, 16'hCAFE};

    // Reset state
    tick();
    tick();
    check("reset_rd_a", {16'd0, rd_data_a}, 32'd0);
    check("reset_rd_b", {16'd0, rd_data_b}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Vector table: first row writes on the first edge after reset release
    for (int i = 0; i < 9; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      tick();
      check($sformatf("vec%0d_rd_a", i), {16'd0, rd_data_a}, {16'd0, vecs[i].ea});
      check($sformatf("vec%0d_rd_b", i), {16'd0, rd_data_b}, {16'd0, vecs[i].eb});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end
    wr_en = 1'b0;

    // Clear sweep: fill, pulse clr_req, count busy cycles, drop a busy write
    for (int a = 0; a < 8; a++) wr(3'(a), 16'hFFFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      wr_en = 1'b0;
      if (n == 0) begin rd_addr_a = 3'd7; rd_addr_b = 3'd0; end
      if (n == 1) begin
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1111;
        rd_addr_a = 3'd0; rd_addr_b = 3'd7;
      end
      tick();
      n++;
      if (n == 1) begin
        check("sweep_unswept_a", {16'd0, rd_data_a}, 32'hFFFF);
        check("sweep_unswept_b", {16'd0, rd_data_b}, {16'd0, ZF});
      end
      if (n == 2) begin
        check("sweep_swept_a", {16'd0, rd_data_a}, 32'h0000);
        check("sweep_pending_b", {16'd0, rd_data_b}, 32'hFFFF);
      end
    end
    wr_en = 1'b0;
    check("clr_busy_cycles", n, 32'd8);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
      tick();
      check($sformatf("cleared_a%0d", a), {16'd0, rd_data_a}, 32'd0);
      check($sformatf("cleared_b%0d", 7 - a), {16'd0, rd_data_b}, 32'd0);
    end

    // Clear/write collision: write dropped, no bypass of the dropped data
    wr(3'd2, 16'h2222);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hAAAA;
    rd_addr_a = 3'd2;
    tick();
    clr_req = 1'b0; wr_en = 1'b0;
    check("collide_no_bypass", {16'd0, rd_data_a}, 32'h2222);
    wait_idle("collide_idle");
    tick();
    check("collide_addr2_zero", {16'd0, rd_data_a}, 32'd0);

    // Reset during the fourth CLEAR cycle
    wr(3'd4, 16'h4444);
    wr(3'd5, 16'h5A5A);
    rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    tick();
    check("midsweep_busy", {31'd0, busy}, 32'd1);
    check("midsweep_old_a", {16'd0, rd_data_a}, 32'h4444);
    #1 rst = 1'b1;
    #1;
    check("rst_busy_now", {31'd0, busy}, 32'd0);
    check("rst_rd_a_now", {16'd0, rd_data_a}, 32'd0);
    check("rst_rd_b_now", {16'd0, rd_data_b}, 32'd0);
    tick();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h9999;
    rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    tick();
    wr_en = 1'b0;
    check("post_rst_write_a", {16'd0, rd_data_a}, 32'h9999);
    check("post_rst_entry5", {16'd0, rd_data_b}, 32'd0);
    rd_addr_b = 3'd3;
    tick();
    check("post_rst_read_a", {16'd0, rd_data_a}, 32'h9999);
    check("post_rst_entry3", {16'd0, rd_data_b}, 32'd0);
    for (int k = 0; k < 10; k++) tick();
    check("no_sweep_resume", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each register and of every data port.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries (derived, not overridable).
REQ-003 SHALL have port clk  in  1: single clock, rising edge active.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  in  1: write request this cycle.
REQ-006 SHALL have port wr_addr  in  ADDR_W: write address, independent of both read addresses.
REQ-007 SHALL have port wr_data  in  DATA_W: write data.
REQ-008 SHALL have port rd_addr_a  in  ADDR_W: read port A address.
REQ-009 SHALL have port rd_addr_b  in  ADDR_W: read port B address.
REQ-010 SHALL have port rd_data_a  out  DATA_W: registered read data, port A.
REQ-011 SHALL have port rd_data_b  out  DATA_W: registered read data, port B.
REQ-012 SHALL have port clr_req  in  1: single-cycle request to zero the whole array.
REQ-013 SHALL have port busy  out  1: clear sweep in progress.

Function
REQ-014 SHALL perform a write on the rising edge when wr_en=1 and the write is accepted; wr_en=1 while busy=1, or in the same cycle as an accepted clr_req, SHALL be dropped.
REQ-015 SHALL register both reads: rd_data_x = contents at rd_addr_x as sampled on edge N, valid after edge N (1-cycle latency); ports A and B are fully independent.
REQ-016 SHALL bypass write-first: if an accepted write has wr_addr == rd_addr_x on the same edge, rd_data_x SHALL take wr_data, not the old value; this applies to A and B simultaneously.
REQ-017 SHALL implement FSM with states IDLE and CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after entry DEPTH-1 is zeroed.
REQ-018 SHALL, in CLEAR, zero one entry per cycle via an internal ADDR_W-bit sweep index running 0..DEPTH-1; busy=1 for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
REQ-019 SHALL ignore clr_req while busy=1; a sweep in progress is never restarted or extended.
REQ-020 SHALL, during CLEAR, keep serving reads from current array contents: an entry already swept reads 0, an entry not yet swept reads its old value.
REQ-021 SHALL wrap no address: each address selects exactly one of DEPTH entries, and the sweep index is reset to 0 on leaving CLEAR.

Reset
REQ-022 SHALL, on rst=1, asynchronously set all DEPTH entries, rd_data_a, rd_data_b and the sweep index to 0, set busy=0, and set the state to IDLE.
REQ-023 SHALL, if rst asserts mid-sweep, abort the sweep; after rst deasserts the block is in IDLE with all entries 0, and no sweep resumes.
REQ-024 SHALL accept writes and clr_req on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support macro REGFILE_ZERO_REG_EN: when defined, entry 0 is hardwired to 0, writes to address 0 are discarded, and reads of address 0 return 0 (including the bypass case).
REQ-026 SHALL, without REGFILE_ZERO_REG_EN, treat entry 0 as an ordinary writable register.

Structure
REQ-027 SHALL place the state enum (IDLE, CLEAR) and the DATA_W/ADDR_W defaults in shared package regfile_pkg.
REQ-028 SHALL implement the clear FSM, sweep index and busy output in one sub-module, regfile_clear_seq; the array, write logic and read/bypass logic stay in the top level.

Verification
REQ-029 SHALL cover basic write/read: write 0xBEEF to addr 5, then read A=5 -> rd_data_a=0xBEEF one cycle after the read address is applied.
REQ-030 SHALL cover bypass: wr_en=1, wr_addr=3, wr_data=0x1234, with rd_addr_a=3 and rd_addr_b=3 on the same edge -> both ports read 0x1234 after that edge.
REQ-031 SHALL cover clear: fill all 8 entries with 0xFFFF, pulse clr_req -> busy high for exactly 8 cycles; then every address reads 0; a write issued during busy is lost.
REQ-032 SHALL cover clear/write collision: clr_req=1 and wr_en=1 (addr 2, 0xAAAA) in IDLE -> the write is dropped and addr 2 reads 0 after the sweep.
REQ-033 SHALL cover reset mid-sweep: assert rst during cycle 4 of CLEAR -> busy=0 immediately, all reads return 0, and a write on the next edge succeeds.
REQ-034 SHALL cover the zero register with REGFILE_ZERO_REG_EN defined: write 0x5555 to addr 0 -> reads of addr 0 return 0, including the same-cycle bypass case.
